lif_tdm_scheduler: RTL and testbench

//  Time-multiplexes one shared leaky-integrate-and-fire (LIF) update datapath across NUM_NEURONS virtual neurons.

---
 rtl/lif_tdm_scheduler.sv | 132 +++++++++++++
 tb/tb_lif_tdm_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed LIF neuron array: one shared update datapath swept round-robin
// over NUM_NEURONS membrane states, with spike ids queued in a small event FIFO.
module lif_tdm_scheduler #(
  parameter int unsigned NUM_NEURONS = 5,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned REFRACT     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       cfg_threshold,
  input  logic [2:0]       cfg_leak_shift,
  output logic [IDX_W-1:0] cur_idx,
  input  logic [7:0]       cur_data,
  output logic             spk_valid,
  input  logic             spk_ready,
  output logic [IDX_W-1:0] spk_id,
  output logic             frame_done,
  output logic [7:0]       ovf_cnt,
  input  logic [IDX_W-1:0] state_rd_idx,
  output logic [7:0]       state_rd_data
);
  localparam int unsigned      PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      CNT_W     = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W:0]   NUM_EXT   = (IDX_W+1)'(NUM_NEURONS);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       REFR_INIT = 4'(REFRACT);

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE} fsm_t;

  fsm_t             fsm;
  logic [7:0]       cur_q;
  logic [7:0]       mem_state [NUM_NEURONS];
  logic [3:0]       refr      [NUM_NEURONS];
  logic [IDX_W-1:0] fifo_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [7:0]       st;
  logic [7:0]       leak;
  logic [7:0]       diff;
  logic [7:0]       nxt;
  logic [9:0]       sum;
  logic             refr_busy;
  logic             spike;
  logic             pop;
  logic             full;
  logic             push;
  logic             drop;
  logic [CNT_W-1:0] count_nxt;
  logic [PTR_W-1:0] head_ptr;

  // Shared LIF datapath plus FIFO push/pop arbitration for the current neuron.
  always_comb begin
    st        = mem_state[cur_idx];
    refr_busy = (refr[cur_idx] != 4'd0);
    leak      = st >> cfg_leak_shift;
    diff      = st - leak;
    sum       = {2'b00, diff} + {2'b00, cur_q};
    nxt       = (sum > 10'd255) ? 8'hFF : sum[7:0];
    spike     = (fsm == UPDATE) && !refr_busy && (nxt >= cfg_threshold);
    pop       = spk_valid && spk_ready;
    full      = (count == DEPTH_CNT);
    push      = spike && (!full || pop);
    drop      = spike && full && !pop;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    head_ptr  = rd_ptr + PTR_W'(pop);
  end

  always_comb begin
    state_rd_data = 8'd0;
    if ({1'b0, state_rd_idx} < NUM_EXT) state_rd_data = mem_state[state_rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      cur_idx    <= '0;
      cur_q      <= '0;
      frame_done <= 1'b0;
      ovf_cnt    <= '0;
      spk_valid  <= 1'b0;
      spk_id     <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        mem_state[i] <= '0;
        refr[i]      <= '0;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      case (fsm)
        IDLE: if (ena) fsm <= FETCH;
        FETCH: begin
          cur_q <= cur_data;
          fsm   <= UPDATE;
        end
        UPDATE: begin
          if (refr_busy) begin
            mem_state[cur_idx] <= 8'd0;
            refr[cur_idx]      <= refr[cur_idx] - 4'd1;
          end else if (spike) begin
            mem_state[cur_idx] <= 8'd0;
            refr[cur_idx]      <= REFR_INIT;
          end else begin
            mem_state[cur_idx] <= nxt;
          end
          frame_done <= (cur_idx == LAST_IDX);
          cur_idx    <= (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
          fsm        <= ena ? FETCH : IDLE;
        end
        default: fsm <= IDLE;
      endcase

      if (push) begin
        fifo_mem[wr_ptr] <= cur_idx;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= head_ptr;
      count     <= count_nxt;
      spk_valid <= (count_nxt != '0);
      // Head is registered; a push into an empty (or draining-to-empty) FIFO becomes the new head.
      spk_id    <= (push && (wr_ptr == head_ptr)) ? cur_idx : fifo_mem[head_ptr];
      if (drop && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed bench for lif_tdm_scheduler: sweep timing, integrate/fire, saturation,
// leak shift, FIFO overflow and simultaneous push/pop, disable and async reset.
module tb_lif_tdm_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] thr = 8'd255;
  logic [2:0] shift = 3'd7;
  logic [2:0] cur_idx;
  logic [7:0] cur_data;
  logic       spk_valid;
  logic       spk_ready = 1'b0;
  logic [2:0] spk_id;
  logic       frame_done;
  logic [7:0] ovf_cnt;
  logic [2:0] state_rd_idx = 3'd0;
  logic [7:0] state_rd_data;
  logic [7:0] cur_tab [8];
  int         total = 0;
  int         bad = 0;

  lif_tdm_scheduler dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cfg_threshold(thr), .cfg_leak_shift(shift),
    .cur_idx(cur_idx), .cur_data(cur_data),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_id(spk_id),
    .frame_done(frame_done), .ovf_cnt(ovf_cnt),
    .state_rd_idx(state_rd_idx), .state_rd_data(state_rd_data)
  );

  always #5 clk = ~clk;

  // Upstream current source: per-neuron current selected by the index being fetched.
  assign cur_data = cur_tab[cur_idx];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    state_rd_idx = idx;
    #1;
    chk(tag, 32'(state_rd_data), exp);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 8; i++) cur_tab[i] = 8'd0;
  endtask

  // Leaves the bench 1 time unit after a posedge with ena low; that edge is edge 0.
  task automatic do_reset();
    ena = 1'b0;
    spk_ready = 1'b0;
    rst_n = 1'b0;
    edges(1);
    rst_n = 1'b1;
    edges(1);
  endtask

  initial begin
    clear_tab();

    // T1: reset values, idle hold, sweep index sequence and frame_done period
    do_reset();
    chk("rst_cur_idx", 32'(cur_idx), 0);
    chk("rst_spk_valid", 32'(spk_valid), 0);
    chk("rst_spk_id", 32'(spk_id), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 0);
    chk_state("rst_state0", 3'd0, 0);
    edges(2);
    chk("idle_cur_idx", 32'(cur_idx), 0);
    chk("idle_frame_done", 32'(frame_done), 0);
    ena = 1'b1;
    for (int k = 0; k < 11; k++) begin
      edges(1);
      chk("t1_cur_idx", 32'(cur_idx), (k < 10) ? k / 2 : 0);
      chk("t1_frame_done", 32'(frame_done), (k == 10) ? 1 : 0);
    end
    for (int k = 1; k <= 20; k++) begin
      edges(1);
      chk("t1_frame_period", 32'(frame_done), (k == 10 || k == 20) ? 1 : 0);
    end

    // T2: integrate and fire on neuron 0, then refractory hold
    clear_tab();
    cur_tab[0] = 8'd30;
    thr = 8'd100;
    shift = 3'd7;
    do_reset();
    ena = 1'b1;
    edges(3);
    chk_state("t2_v1", 3'd0, 30);
    edges(10);
    chk_state("t2_v2", 3'd0, 60);
    edges(10);
    chk_state("t2_v3", 3'd0, 90);
    chk("t2_no_spike_yet", 32'(spk_valid), 0);
    edges(10);
    chk_state("t2_v4_fire", 3'd0, 0);
    chk("t2_spk_valid", 32'(spk_valid), 1);
    chk("t2_spk_id", 32'(spk_id), 0);
    edges(10);
    chk_state("t2_refr1", 3'd0, 0);
    edges(10);
    chk_state("t2_refr2", 3'd0, 0);
    edges(10);
    chk_state("t2_resume", 3'd0, 30);
    chk("t2_ovf", 32'(ovf_cnt), 0);
    spk_ready = 1'b1;
    edges(1);
    chk("t2_drained", 32'(spk_valid), 0);
    spk_ready = 1'b0;

    // T3: saturation at 255 fires with threshold 255; out-of-range readback is 0
    clear_tab();
    cur_tab[0] = 8'd200;
    thr = 8'd255;
    shift = 3'd7;
    do_reset();
    ena = 1'b1;
    edges(3);
    chk_state("t3_v1", 3'd0, 200);
    chk_state("t3_rd_idx5", 3'd5, 0);
    chk_state("t3_rd_idx7", 3'd7, 0);
    edges(10);
    chk_state("t3_sat_fire", 3'd0, 0);
    chk("t3_spk_valid", 32'(spk_valid), 1);
    chk("t3_spk_id", 32'(spk_id), 0);

    // T3b: leak shift 0 is a full leak; shift 1 halves the old state
    clear_tab();
    cur_tab[0] = 8'd40;
    thr = 8'd255;
    shift = 3'd0;
    do_reset();
    ena = 1'b1;
    edges(3);
    chk_state("t3b_v1", 3'd0, 40);
    shift = 3'd1;
    edges(10);
    chk_state("t3b_shift1", 3'd0, 60);
    shift = 3'd0;
    edges(10);
    chk_state("t3b_shift0", 3'd0, 40);

    // T4: threshold 0 with no consumer: 4 queued, 5th dropped, then in-order drain
    clear_tab();
    thr = 8'd0;
    shift = 3'd7;
    do_reset();
    ena = 1'b1;
    edges(3);
    chk("t4_first_valid", 32'(spk_valid), 1);
    chk("t4_first_id", 32'(spk_id), 0);
    edges(8);
    chk("t4_ovf", 32'(ovf_cnt), 1);
    ena = 1'b0;
    edges(4);
    chk("t4_idle_idx", 32'(cur_idx), 1);
    chk("t4_ovf_hold", 32'(ovf_cnt), 1);
    spk_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_pop_valid", 32'(spk_valid), 1);
      chk("t4_pop_id", 32'(spk_id), k);
      edges(1);
    end
    chk("t4_empty", 32'(spk_valid), 0);
    spk_ready = 1'b0;

    // T5: full FIFO, pop in the same cycle as a spike: push accepted, no drop
    do_reset();
    ena = 1'b1;
    edges(10);
    spk_ready = 1'b1;
    edges(1);
    ena = 1'b0;
    spk_ready = 1'b0;
    chk("t5_ovf", 32'(ovf_cnt), 0);
    chk("t5_head", 32'(spk_id), 1);
    chk("t5_frame_done", 32'(frame_done), 1);
    edges(4);
    spk_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t5_pop_valid", 32'(spk_valid), 1);
      chk("t5_pop_id", 32'(spk_id), k);
      edges(1);
    end
    chk("t5_empty", 32'(spk_valid), 0);
    spk_ready = 1'b0;

    // T6: ena drops during FETCH of neuron 2; its UPDATE completes, resume at 3
    clear_tab();
    cur_tab[2] = 8'd50;
    thr = 8'd255;
    do_reset();
    ena = 1'b1;
    edges(5);
    ena = 1'b0;
    chk("t6_fetch2_idx", 32'(cur_idx), 2);
    edges(1);
    chk("t6_update2_idx", 32'(cur_idx), 2);
    edges(1);
    chk("t6_idle_idx", 32'(cur_idx), 3);
    chk_state("t6_state2", 3'd2, 50);
    edges(5);
    chk("t6_idle_hold_idx", 32'(cur_idx), 3);
    chk_state("t6_state2_hold", 3'd2, 50);
    ena = 1'b1;
    edges(1);
    chk("t6_resume_fetch", 32'(cur_idx), 3);
    edges(1);
    chk("t6_resume_update", 32'(cur_idx), 3);
    edges(1);
    chk("t6_resume_next", 32'(cur_idx), 4);

    // T6b: async reset mid-sweep with state, full FIFO and overflow count live
    clear_tab();
    cur_tab[0] = 8'd150;
    cur_tab[1] = 8'd150;
    cur_tab[2] = 8'd10;
    cur_tab[3] = 8'd150;
    cur_tab[4] = 8'd150;
    thr = 8'd100;
    shift = 3'd7;
    do_reset();
    ena = 1'b1;
    edges(33);
    chk("t6b_pre_ovf", 32'(ovf_cnt), 1);
    chk("t6b_pre_valid", 32'(spk_valid), 1);
    chk("t6b_pre_id", 32'(spk_id), 0);
    chk_state("t6b_pre_state2", 3'd2, 30);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6b_rst_ovf", 32'(ovf_cnt), 0);
    chk("t6b_rst_valid", 32'(spk_valid), 0);
    chk("t6b_rst_idx", 32'(cur_idx), 0);
    chk("t6b_rst_frame", 32'(frame_done), 0);
    chk_state("t6b_rst_state2", 3'd2, 0);
    ena = 1'b0;
    edges(1);
    rst_n = 1'b1;
    edges(2);
    chk("t6b_post_idx", 32'(cur_idx), 0);
    chk("t6b_post_valid", 32'(spk_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
